mul4_fitness_scorer: RTL and testbench

- Sequential evaluation harness placed around one evolved 4-limb multiplier individual (combinational; a1,a0,b1,b0 in, y3..y0 out, 16-bit limbs).
- Generates pseudo-random 32x32 operand pairs, drives them into the individual, and computes the golden 64-bit product with an internal shift-add multiplier.
- Compares the individual's outputs against the golden product and accumulates a fitness score for the tournament selection logic downstream.

---
 rtl/mul4_fitness_scorer.sv | 140 ++++++++++++++
 tb/tb_mul4_fitness_scorer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul4_fitness_scorer.sv
// Fitness harness around one combinational 4-limb multiplier individual: generates LFSR
// operand pairs, computes the golden product by shift-add, and scores the individual's bits.
module mul4_fitness_scorer #(
  parameter int          NUM_VECTORS = 64,
  parameter logic [31:0] SEED        = 32'hACE1_1234,
  parameter int          SCORE_W     = 16,
  parameter int          CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [15:0]        cand_a1,
  output logic [15:0]        cand_a0,
  output logic [15:0]        cand_b1,
  output logic [15:0]        cand_b0,
  input  logic [15:0]        cand_y3,
  input  logic [15:0]        cand_y2,
  input  logic [15:0]        cand_y1,
  input  logic [15:0]        cand_y0,
  output logic [SCORE_W-1:0] bit_score,
  output logic [CNT_W-1:0]   vec_pass
);

  localparam logic [31:0]        TAPS      = 32'h8020_0003;
  localparam logic [31:0]        SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [CNT_W-1:0]   LAST_VEC  = CNT_W'(NUM_VECTORS - 1);
  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(64 * NUM_VECTORS);

  typedef enum logic [2:0] {S_IDLE, S_GEN_A, S_GEN_B, S_MUL, S_CMP, S_DONE} state_t;

  state_t             state, state_next;
  logic [31:0]        lfsr;
  logic [31:0]        a_reg;
  logic [31:0]        mplier;
  logic [63:0]        mcand;
  logic [63:0]        prod;
  logic [4:0]         bit_cnt;
  logic [CNT_W-1:0]   vec_cnt;
  logic [63:0]        cand_y;

  assign cand_y = {cand_y3, cand_y2, cand_y1, cand_y0};

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : 32'h0);
  endfunction

  function automatic logic [6:0] popcount64(input logic [63:0] x);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + 7'(x[i]);
    return c;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_GEN_A;
      S_GEN_A: state_next = S_GEN_B;
      S_GEN_B: state_next = S_MUL;
      S_MUL:   if (bit_cnt == 5'd31) state_next = S_CMP;
      S_CMP:   state_next = (vec_cnt == LAST_VEC) ? S_DONE : S_GEN_A;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_GEN_A) || (state == S_GEN_B) || (state == S_MUL) || (state == S_CMP);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr      <= SEED_EFF;
      a_reg     <= '0;
      mplier    <= '0;
      mcand     <= '0;
      prod      <= '0;
      bit_cnt   <= '0;
      vec_cnt   <= '0;
      bit_score <= '0;
      vec_pass  <= '0;
      cand_a1   <= '0;
      cand_a0   <= '0;
      cand_b1   <= '0;
      cand_b0   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lfsr      <= SEED_EFF;
            bit_score <= '0;
            vec_pass  <= '0;
            vec_cnt   <= '0;
          end
        end
        S_GEN_A: begin
          a_reg <= lfsr;
          lfsr  <= lfsr_step(lfsr);
        end
        S_GEN_B: begin
          // The current LFSR word is operand B; both operands reach the individual here.
          lfsr    <= lfsr_step(lfsr);
          cand_a1 <= a_reg[31:16];
          cand_a0 <= a_reg[15:0];
          cand_b1 <= lfsr[31:16];
          cand_b0 <= lfsr[15:0];
          mcand   <= {32'h0, a_reg};
          mplier  <= lfsr;
          prod    <= '0;
          bit_cnt <= '0;
        end
        S_MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          bit_cnt <= bit_cnt + 5'd1;
        end
        S_CMP: begin
          bit_score <= bit_score + SCORE_W'(popcount64(~(cand_y ^ prod)));
          if (cand_y == prod) vec_pass <= vec_pass + CNT_W'(1);
          vec_cnt <= vec_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  score_bound: assert property (@(posedge clk) disable iff (rst) bit_score <= MAX_SCORE);

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Bench for mul4_fitness_scorer: stub individuals around three harness instances, a
// plain-arithmetic reference model, table-driven runs and hand-written corner sequences.
module tb_mul4_fitness_scorer;

  typedef enum logic [2:0] {M_GOLD, M_ZERO, M_INV, M_RAND, M_CONST} mode_e;

  typedef struct {
    mode_e       mode;
    logic [63:0] mask;
    int          exp_score;
    int          exp_pass;
    bit          pulse_mid;
    bit          pulse_done;
    int          gap;
  } vec_t;

  localparam logic [31:0] TAPS     = 32'h8020_0003;
  localparam logic [31:0] U0_SEED  = 32'hACE1_1234;
  localparam logic [63:0] ONES_SQ  = 64'hFFFF_FFFE_0000_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [15:0] ca1 [3], ca0 [3], cb1 [3], cb0 [3];
  logic [63:0] yv  [3];
  logic [15:0] score_v [3];
  logic [7:0]  pass_v  [3];
  mode_e       mode_v  [3];
  logic [63:0] mask_v  [3];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mul4_fitness_scorer #(.NUM_VECTORS(4)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .cand_a1(ca1[0]), .cand_a0(ca0[0]), .cand_b1(cb1[0]), .cand_b0(cb0[0]),
    .cand_y3(yv[0][63:48]), .cand_y2(yv[0][47:32]), .cand_y1(yv[0][31:16]), .cand_y0(yv[0][15:0]),
    .bit_score(score_v[0]), .vec_pass(pass_v[0]));

  mul4_fitness_scorer #(.NUM_VECTORS(1), .SEED(32'h1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .cand_a1(ca1[1]), .cand_a0(ca0[1]), .cand_b1(cb1[1]), .cand_b0(cb0[1]),
    .cand_y3(yv[1][63:48]), .cand_y2(yv[1][47:32]), .cand_y1(yv[1][31:16]), .cand_y0(yv[1][15:0]),
    .bit_score(score_v[1]), .vec_pass(pass_v[1]));

  mul4_fitness_scorer #(.NUM_VECTORS(1), .SEED(32'h0)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .cand_a1(ca1[2]), .cand_a0(ca0[2]), .cand_b1(cb1[2]), .cand_b0(cb0[2]),
    .cand_y3(yv[2][63:48]), .cand_y2(yv[2][47:32]), .cand_y1(yv[2][31:16]), .cand_y0(yv[2][15:0]),
    .bit_score(score_v[2]), .vec_pass(pass_v[2]));

  // Behaviour of the stand-in individual for each mode.
  function automatic logic [63:0] stub(input mode_e m, input logic [63:0] mask,
                                       input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'h0, a} * {32'h0, b};
    case (m)
      M_GOLD:  return p;
      M_ZERO:  return 64'h0;
      M_INV:   return ~p;
      M_RAND:  return (a[0] ^ b[1]) ? (p ^ mask) : p;
      default: return ONES_SQ;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++)
      yv[i] = stub(mode_v[i], mask_v[i], {ca1[i], ca0[i]}, {cb1[i], cb0[i]});
  end

  function automatic logic [31:0] next_rand(input logic [31:0] x);
    if (x[0]) return (x >> 1) ^ TAPS;
    else      return x >> 1;
  endfunction

  // Whole-run reference: operand sequence, golden products, score totals.
  task automatic model_run(input logic [31:0] seed, input int n, input mode_e m,
                           input logic [63:0] mask, output int score, output int pass,
                           output logic [31:0] last_a, output logic [31:0] last_b);
    logic [31:0] l;
    logic [63:0] p, y;
    l = (seed == 32'h0) ? 32'h1 : seed;
    score = 0;
    pass  = 0;
    last_a = '0;
    last_b = '0;
    for (int v = 0; v < n; v++) begin
      last_a = l;
      l = next_rand(l);
      last_b = l;
      l = next_rand(l);
      p = {32'h0, last_a} * {32'h0, last_b};
      y = stub(m, mask, last_a, last_b);
      score += 64 - $countones(y ^ p);
      if (y == p) pass++;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input int idx, input string tag);
    check({tag, " busy"}, 64'(busy_v[idx]), 64'h0);
    check({tag, " done"}, 64'(done_v[idx]), 64'h0);
    check({tag, " bit_score"}, 64'(score_v[idx]), 64'h0);
    check({tag, " vec_pass"}, 64'(pass_v[idx]), 64'h0);
    check({tag, " cand"}, {ca1[idx], ca0[idx], cb1[idx], cb0[idx]}, 64'h0);
  endtask

  // Launch a run on instance idx and watch it until done (bounded); optional ignored start pulses.
  task automatic run(input int idx, input int n, input bit pulse_mid, input bit pulse_done,
                     output int lat, output int busy_cycles);
    bit seen;
    int i;
    lat = -1;
    busy_cycles = 0;
    seen = 1'b0;
    @(negedge clk) start_v[idx] = 1'b1;
    @(negedge clk) start_v[idx] = 1'b0;
    i = 1;
    while (!seen && i <= 35 * n + 10) begin
      if (busy_v[idx]) busy_cycles++;
      if (done_v[idx]) begin
        seen = 1'b1;
        lat = i - 1;
        if (pulse_done) start_v[idx] = 1'b1;
      end else begin
        if (pulse_mid && i == 20) start_v[idx] = 1'b1;
        @(negedge clk) start_v[idx] = 1'b0;
        i++;
      end
    end
    if (!seen) check("run timeout", 64'h0, 64'h1);
  endtask

  vec_t        tbl [8];
  int          lat, bcy, m_score, m_pass, done_cnt;
  logic [31:0] m_a, m_b;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = M_GOLD;
      mask_v[i]  = 64'h0;
    end
    repeat (2) @(negedge clk);
    check_quiet(0, "reset");
    rst = 1'b0;

    tbl[0] = '{M_GOLD,  64'h0, 256, 4, 1'b0, 1'b0, 2};
    tbl[1] = '{M_INV,   64'h0,   0, 0, 1'b0, 1'b0, 2};
    tbl[2] = '{M_GOLD,  64'h0, 256, 4, 1'b1, 1'b1, 2};
    tbl[3] = '{M_GOLD,  64'h0, 256, 4, 1'b0, 1'b0, 0};
    for (int i = 4; i < 8; i++) begin
      tbl[i].mode = M_RAND;
      tbl[i].mask = {$urandom, $urandom};
      model_run(U0_SEED, 4, M_RAND, tbl[i].mask, m_score, m_pass, m_a, m_b);
      tbl[i].exp_score  = m_score;
      tbl[i].exp_pass   = m_pass;
      tbl[i].pulse_mid  = 1'b0;
      tbl[i].pulse_done = 1'b0;
      tbl[i].gap        = int'($urandom_range(1, 6));
    end

    for (int t = 0; t < 8; t++) begin
      repeat (tbl[t].gap) @(negedge clk);
      mode_v[0] = tbl[t].mode;
      mask_v[0] = tbl[t].mask;
      run(0, 4, tbl[t].pulse_mid, tbl[t].pulse_done, lat, bcy);
      check($sformatf("vec%0d bit_score", t), 64'(score_v[0]), 64'(tbl[t].exp_score));
      check($sformatf("vec%0d vec_pass", t), 64'(pass_v[0]), 64'(tbl[t].exp_pass));
      check($sformatf("vec%0d latency", t), 64'(lat), 64'd140);
      check($sformatf("vec%0d busy cycles", t), 64'(bcy), 64'd140);
      if (t == 0) begin
        model_run(U0_SEED, 4, M_GOLD, 64'h0, m_score, m_pass, m_a, m_b);
        check("last cand_a", 64'({ca1[0], ca0[0]}), 64'(m_a));
        check("last cand_b", 64'({cb1[0], cb0[0]}), 64'(m_b));
      end
    end

    // Reset in the middle of vector 2's multiply, then a clean rerun.
    repeat (3) @(negedge clk);
    mode_v[0] = M_GOLD;
    @(negedge clk) start_v[0] = 1'b1;
    @(negedge clk) start_v[0] = 1'b0;
    repeat (45) @(negedge clk);
    check("pre-reset busy", 64'(busy_v[0]), 64'h1);
    rst = 1'b1;
    #1;
    check_quiet(0, "mid-run reset");
    @(negedge clk) rst = 1'b0;
    done_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (done_v[0]) done_cnt++;
    end
    check("no done after reset", 64'(done_cnt), 64'h0);
    run(0, 4, 1'b0, 1'b0, lat, bcy);
    check("rerun bit_score", 64'(score_v[0]), 64'd256);
    check("rerun vec_pass", 64'(pass_v[0]), 64'd4);
    check("rerun latency", 64'(lat), 64'd140);

    // Zero-output individual, seed 1 and seed 0.
    for (int k = 1; k < 3; k++) begin
      mode_v[k] = M_ZERO;
      run(k, 1, 1'b0, 1'b0, lat, bcy);
      model_run((k == 1) ? 32'h1 : 32'h0, 1, M_ZERO, 64'h0, m_score, m_pass, m_a, m_b);
      check($sformatf("u%0d first A", k), 64'({ca1[k], ca0[k]}), 64'h1);
      check($sformatf("u%0d first B", k), 64'({cb1[k], cb0[k]}), 64'(m_b));
      check($sformatf("u%0d zero bit_score", k), 64'(score_v[k]), 64'(m_score));
      check($sformatf("u%0d zero vec_pass", k), 64'(pass_v[k]), 64'h0);
      check($sformatf("u%0d latency", k), 64'(lat), 64'd35);
    end

    // All-ones operands exercise every carry of the shift-add path.
    force u1.lfsr = 32'hFFFF_FFFF;
    mode_v[1] = M_CONST;
    run(1, 1, 1'b0, 1'b0, lat, bcy);
    check("ones cand_a", 64'({ca1[1], ca0[1]}), 64'hFFFF_FFFF);
    check("ones cand_b", 64'({cb1[1], cb0[1]}), 64'hFFFF_FFFF);
    check("ones vec_pass", 64'(pass_v[1]), 64'h1);
    check("ones bit_score", 64'(score_v[1]), 64'd64);
    mode_v[1] = M_INV;
    run(1, 1, 1'b0, 1'b0, lat, bcy);
    check("ones inverse bit_score", 64'(score_v[1]), 64'h0);
    check("ones inverse vec_pass", 64'(pass_v[1]), 64'h0);
    release u1.lfsr;

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
